// File: rtl/fetch_pkg.sv
// Fetch-stage shared types: FSM state encoding, PC defaults and the HLT opcode.
// No logic; latency and backpressure are defined by the modules that import it.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        OUT,
        HALT
    } fetch_state_e;

    localparam int unsigned PC_W_DEF     = 16;
    localparam int unsigned INST_W_DEF   = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;
    localparam logic [15:0] PC_INC_DEF   = 16'd2;
    localparam logic [3:0]  HLT_OPCODE   = 4'hF;

endpackage

// File: rtl/fetch_pc_reg.sv
// Architectural PC register: load beats increment, otherwise hold; one cycle to update.
// No backpressure; the owner decides when to load or increment.
module fetch_pc_reg #(
    parameter int unsigned      PC_W     = 16,
    parameter logic [PC_W-1:0]  RESET_PC = '0,
    parameter logic [PC_W-1:0]  PC_INC   = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_load_pc,
    input  logic            i_inc,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;

    // Increment wraps modulo 2^PC_W by construction.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_pc;
        end else if (i_inc) begin
            r_pc <= r_pc + PC_INC;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_pc_sequencer.sv
// PC sequencer: one IMEM request in flight, one-entry output buffer; inst_valid = IMEM latency + 1.
// Stalls in REQ until imem_req_ready and in OUT until inst_ready; optional HLT stop via FETCH_HALT_EN.
module fetch_pc_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned      PC_W     = PC_W_DEF,
    parameter int unsigned      INST_W   = INST_W_DEF,
    parameter logic [PC_W-1:0]  RESET_PC = PC_W'(RESET_PC_DEF),
    parameter logic [PC_W-1:0]  PC_INC   = PC_W'(PC_INC_DEF)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_imem_req_valid,
    input  logic              i_imem_req_ready,
    output logic [PC_W-1:0]   o_imem_addr,
    input  logic              i_imem_rsp_valid,
    input  logic [INST_W-1:0] i_imem_rsp_data,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic [INST_W-1:0] o_inst_data,
    output logic [PC_W-1:0]   o_inst_pc,
    input  logic              i_redirect_valid,
    input  logic [PC_W-1:0]   i_redirect_pc,
    output logic [PC_W-1:0]   o_pc_current,
    output logic              o_halted
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic              r_kill;
    logic              w_kill_nxt;
    logic [INST_W-1:0] r_inst_data;
    logic [PC_W-1:0]   r_inst_pc;
    logic [PC_W-1:0]   w_pc;
    logic [PC_W-1:0]   w_load_pc;
    logic              w_capture;
    logic              w_is_hlt;
    logic              w_hlt_pend;
    logic              w_inc;

    assign w_load_pc = i_redirect_pc & ~PC_W'(1);

    // A killed or redirected response never reaches the buffer and never advances the PC.
    assign w_capture = (r_state == WAIT) && i_imem_rsp_valid && !r_kill && !i_redirect_valid;
    assign w_inc     = w_capture && !w_is_hlt;

`ifdef FETCH_HALT_EN
    logic r_hlt;

    assign w_is_hlt   = (i_imem_rsp_data[INST_W-1 -: 4] == HLT_OPCODE);
    assign w_hlt_pend = r_hlt;
    assign o_halted   = (r_state == HALT);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_hlt <= 1'b0;
        end else if (w_capture) begin
            r_hlt <= w_is_hlt;
        end
    end
`else
    assign w_is_hlt   = 1'b0;
    assign w_hlt_pend = 1'b0;
    assign o_halted   = 1'b0;
`endif

    fetch_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC),
        .PC_INC   (PC_INC)
    ) u_pc_reg (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (i_redirect_valid),
        .i_load_pc (w_load_pc),
        .i_inc     (w_inc),
        .o_pc      (w_pc)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_kill  <= w_kill_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_kill_nxt  = r_kill;
        case (r_state)
            IDLE: w_state_nxt = REQ;
            REQ: begin
                // A redirect coincident with acceptance must discard that request's response.
                if (i_imem_req_ready) begin
                    w_state_nxt = WAIT;
                    w_kill_nxt  = i_redirect_valid;
                end
            end
            WAIT: begin
                if (i_imem_rsp_valid) begin
                    w_kill_nxt  = 1'b0;
                    w_state_nxt = (r_kill || i_redirect_valid) ? REQ : OUT;
                end else if (i_redirect_valid) begin
                    w_kill_nxt = 1'b1;
                end
            end
            OUT: begin
                if (i_redirect_valid) begin
                    w_state_nxt = REQ;
                end else if (i_inst_ready) begin
                    w_state_nxt = w_hlt_pend ? HALT : REQ;
                end
            end
            HALT: begin
                if (i_redirect_valid) begin
                    w_state_nxt = REQ;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_inst_data <= '0;
            r_inst_pc   <= '0;
        end else if (w_capture) begin
            r_inst_data <= i_imem_rsp_data;
            r_inst_pc   <= w_pc;
        end
    end

    assign o_imem_req_valid = (r_state == REQ);
    assign o_imem_addr      = w_pc;
    assign o_inst_valid     = (r_state == OUT);
    assign o_inst_data      = r_inst_data;
    assign o_inst_pc        = r_inst_pc;
    assign o_pc_current     = w_pc;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Bench for fetch_pc_sequencer: IMEM responder model plus a scoreboard of expected {pc, data}.
module tb_fetch_pc_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [15:0] o_imem_addr;
    logic        i_imem_rsp_valid;
    logic [15:0] i_imem_rsp_data;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [15:0] o_inst_data;
    logic [15:0] o_inst_pc;
    logic        i_redirect_valid;
    logic [15:0] i_redirect_pc;
    logic [15:0] o_pc_current;
    logic        o_halted;

    int checks   = 0;
    int failures = 0;
    int n_deliv  = 0;
    int drop_n   = 0;
    int lat      = 1;
    bit rdy_en   = 1'b0;
    bit hlt_en   = 1'b0;
    logic [15:0] hlt_addr = 16'h0000;

    logic [31:0] exp_q[$];
    logic [15:0] req_log[$];

    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [15:0] pend_addr = 16'h0000;
    bit          have = 1'b0;
    bit          cur_ok = 1'b0;
    logic [31:0] cur_exp = 32'h0;

    always #5 i_clk = ~i_clk;

    fetch_pc_sequencer dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .o_inst_valid     (o_inst_valid),
        .i_inst_ready     (i_inst_ready),
        .o_inst_data      (o_inst_data),
        .o_inst_pc        (o_inst_pc),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_pc_current     (o_pc_current),
        .o_halted         (o_halted)
    );

    function automatic logic [15:0] mem(input logic [15:0] a);
        if (hlt_en && a == hlt_addr) return 16'hF000;
        return {4'h3, a[11:0] ^ 12'hA5C};
    endfunction

    // IMEM model: accepts at the negedge before the handshake edge, replies lat cycles later.
    always @(negedge i_clk) begin
        i_imem_rsp_valid = 1'b0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                pend             = 1'b0;
                i_imem_rsp_valid = 1'b1;
                i_imem_rsp_data  = mem(pend_addr);
                if (drop_n > 0) drop_n--;
                else exp_q.push_back({pend_addr, mem(pend_addr)});
            end
        end
        i_imem_req_ready = rdy_en;
        if (o_imem_req_valid && rdy_en) begin
            pend      = 1'b1;
            pend_addr = o_imem_addr;
            pend_cnt  = lat;
            req_log.push_back(o_imem_addr);
        end
    end

    // Output monitor: each new instruction is popped from the scoreboard and must hold while valid.
    always @(negedge i_clk) begin
        if (o_inst_valid) begin
            if (!have) begin
                have = 1'b1;
                n_deliv++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    cur_ok = 1'b0;
                    $display("FAIL inst_unexpected pc=%h data=%h required=none", o_inst_pc, o_inst_data);
                end else begin
                    cur_exp = exp_q.pop_front();
                    cur_ok  = 1'b1;
                    if ({o_inst_pc, o_inst_data} !== cur_exp) begin
                        failures++;
                        $display("FAIL inst_out pc/data=%h required=%h", {o_inst_pc, o_inst_data}, cur_exp);
                    end
                end
            end else if (cur_ok) begin
                checks++;
                if ({o_inst_pc, o_inst_data} !== cur_exp) begin
                    failures++;
                    $display("FAIL inst_stable pc/data=%h required=%h", {o_inst_pc, o_inst_data}, cur_exp);
                end
            end
        end else begin
            have = 1'b0;
        end
    end

    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    task automatic wait_deliv(input int target);
        int k = 0;
        while (n_deliv < target && k < 60) begin
            tick();
            k++;
        end
    endtask

    task automatic redirect(input logic [15:0] pc);
        i_redirect_valid = 1'b1;
        i_redirect_pc    = pc;
        tick();
        i_redirect_valid = 1'b0;
    endtask

    task automatic quiesce();
        rdy_en       = 1'b0;
        i_inst_ready = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        i_rst = 1'b0; i_inst_ready = 1'b1; i_redirect_valid = 1'b0; i_redirect_pc = 16'h0;
        i_imem_req_ready = 1'b0; i_imem_rsp_valid = 1'b0; i_imem_rsp_data = 16'h0;
        tick();
        checks++;
        if ({o_imem_req_valid, o_inst_valid, o_halted, o_pc_current, o_inst_data, o_inst_pc} !== 51'h0) begin
            failures++;
            $display("FAIL reset_state vld=%b%b%b pc=%h data=%h ipc=%h required=all zero",
                     o_imem_req_valid, o_inst_valid, o_halted, o_pc_current, o_inst_data, o_inst_pc);
        end
        i_rst = 1'b1;
        checks++;
        if (o_imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL idle_no_req req_valid=%b required=0", o_imem_req_valid);
        end
        tick();
        checks++;
        if (o_imem_req_valid !== 1'b1 || o_imem_addr !== 16'h0000) begin
            failures++; $display("FAIL first_req vld=%b addr=%h required=1/0000", o_imem_req_valid, o_imem_addr);
        end
    endtask

    task automatic test_sequential();
        int base = n_deliv;
        req_log.delete();
        lat = 1; rdy_en = 1'b1;
        wait_deliv(base + 3);
        rdy_en = 1'b0;
        checks++;
        if (n_deliv !== base + 3) begin
            failures++; $display("FAIL seq_deliver count=%0d required=%0d", n_deliv, base + 3);
        end
        checks++;
        if (req_log.size() !== 3 || req_log[0] !== 16'h0000 || req_log[1] !== 16'h0002 || req_log[2] !== 16'h0004) begin
            failures++; $display("FAIL seq_addrs n=%0d required=3 addrs 0000,0002,0004", req_log.size());
        end
        tick();
        checks++;
        if (o_imem_req_valid !== 1'b1 || o_imem_addr !== 16'h0006 || o_pc_current !== 16'h0006) begin
            failures++; $display("FAIL seq_next addr=%h pc=%h required=0006", o_imem_addr, o_pc_current);
        end
    endtask

    task automatic test_backpressure();
        int base = n_deliv;
        i_inst_ready = 1'b0; rdy_en = 1'b1;
        wait_deliv(base + 1);
        rdy_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (o_inst_valid !== 1'b1 || o_imem_req_valid !== 1'b0 ||
                o_inst_pc !== 16'h0006 || o_inst_data !== mem(16'h0006)) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d ivld=%b rvld=%b pc=%h data=%h required=1/0/0006/%h",
                         i, o_inst_valid, o_imem_req_valid, o_inst_pc, o_inst_data, mem(16'h0006));
            end
        end
        i_inst_ready = 1'b1;
        tick();
        checks++;
        if (o_inst_valid !== 1'b0 || o_imem_req_valid !== 1'b1 || o_imem_addr !== 16'h0008) begin
            failures++; $display("FAIL bp_release ivld=%b addr=%h required=0/0008", o_inst_valid, o_imem_addr);
        end
    endtask

    task automatic test_redirect_wait();
        int base = n_deliv;
        lat = 3; drop_n = 1; rdy_en = 1'b1;
        tick();
        rdy_en = 1'b0;
        tick();
        redirect(16'h0101);
        checks++;
        if (o_pc_current !== 16'h0100) begin
            failures++; $display("FAIL rdw_pc pc=%h required=0100", o_pc_current);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (o_inst_valid !== 1'b0) begin
                failures++; $display("FAIL rdw_no_inst cyc=%0d inst_valid=%b required=0", i, o_inst_valid);
            end
        end
        checks++;
        if (o_imem_req_valid !== 1'b1 || o_imem_addr !== 16'h0100 || req_log[req_log.size()-1] !== 16'h0008) begin
            failures++; $display("FAIL rdw_reissue vld=%b addr=%h required=1/0100", o_imem_req_valid, o_imem_addr);
        end
        lat = 1; rdy_en = 1'b1;
        wait_deliv(base + 1);
        rdy_en = 1'b0;
        checks++;
        if (n_deliv !== base + 1) begin
            failures++; $display("FAIL rdw_deliver count=%0d required=%0d", n_deliv, base + 1);
        end
    endtask

    task automatic test_wrap();
        int base;
        quiesce();
        base = n_deliv;
        redirect(16'hFFFF);
        checks++;
        if (o_pc_current !== 16'hFFFE || o_imem_addr !== 16'hFFFE) begin
            failures++; $display("FAIL wrap_load pc=%h required=FFFE", o_pc_current);
        end
        lat = 1; rdy_en = 1'b1;
        wait_deliv(base + 1);
        rdy_en = 1'b0;
        checks++;
        if (n_deliv !== base + 1 || o_pc_current !== 16'h0000) begin
            failures++; $display("FAIL wrap_pc pc=%h required=0000", o_pc_current);
        end
        tick();
        checks++;
        if (o_imem_req_valid !== 1'b1 || o_imem_addr !== 16'h0000) begin
            failures++; $display("FAIL wrap_addr addr=%h required=0000", o_imem_addr);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        redirect(16'h0040);
        lat = 3; drop_n = 1; rdy_en = 1'b1;
        tick();
        rdy_en = 1'b0;
        tick();
        i_rst = 1'b0;
        #1;
        checks++;
        if (o_pc_current !== 16'h0000 || o_inst_data !== 16'h0 || o_inst_pc !== 16'h0 || o_imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL rstmid_clear pc=%h data=%h ipc=%h required=0000/0000/0000",
                                 o_pc_current, o_inst_data, o_inst_pc);
        end
        tick();
        i_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (o_inst_valid !== 1'b0 || o_imem_req_valid !== 1'b1 || o_imem_addr !== 16'h0000) begin
                failures++; $display("FAIL rstmid_stale cyc=%0d ivld=%b rvld=%b addr=%h required=0/1/0000",
                                     i, o_inst_valid, o_imem_req_valid, o_imem_addr);
            end
        end
        base = n_deliv;
        lat = 1; rdy_en = 1'b1;
        wait_deliv(base + 1);
        rdy_en = 1'b0;
        checks++;
        if (n_deliv !== base + 1 || req_log[req_log.size()-1] !== 16'h0000) begin
            failures++; $display("FAIL rstmid_first count=%0d required=%0d at 0000", n_deliv, base + 1);
        end
    endtask

    task automatic test_redirect_out();
        int base = n_deliv;
        i_inst_ready = 1'b0; rdy_en = 1'b1;
        wait_deliv(base + 1);
        rdy_en = 1'b0;
        redirect(16'h0200);
        checks++;
        if (o_inst_valid !== 1'b0 || o_pc_current !== 16'h0200 || o_imem_req_valid !== 1'b1) begin
            failures++; $display("FAIL rdo_drop ivld=%b pc=%h rvld=%b required=0/0200/1",
                                 o_inst_valid, o_pc_current, o_imem_req_valid);
        end
        i_inst_ready = 1'b1;
    endtask

    task automatic test_hlt();
        int base;
        int n_log;
        quiesce();
        hlt_en = 1'b1; hlt_addr = 16'h0006;
        redirect(16'h0006);
        base = n_deliv;
        lat = 1; rdy_en = 1'b1;
        wait_deliv(base + 1);
        rdy_en = 1'b0;
        n_log = req_log.size();
        tick();
`ifdef FETCH_HALT_EN
        checks++;
        if (o_halted !== 1'b1 || o_imem_req_valid !== 1'b0 || o_pc_current !== 16'h0006) begin
            failures++; $display("FAIL hlt_stop halted=%b rvld=%b pc=%h required=1/0/0006",
                                 o_halted, o_imem_req_valid, o_pc_current);
        end
        rdy_en = 1'b1;
        repeat (4) tick();
        checks++;
        if (req_log.size() !== n_log || o_halted !== 1'b1) begin
            failures++; $display("FAIL hlt_hold reqs=%0d required=%0d", req_log.size(), n_log);
        end
        redirect(16'h0010);
        checks++;
        if (o_halted !== 1'b0 || o_imem_req_valid !== 1'b1 || o_imem_addr !== 16'h0010) begin
            failures++; $display("FAIL hlt_exit halted=%b addr=%h required=0/0010", o_halted, o_imem_addr);
        end
`else
        checks++;
        if (o_halted !== 1'b0 || o_imem_req_valid !== 1'b1 || o_imem_addr !== 16'h0008 || req_log.size() !== n_log) begin
            failures++; $display("FAIL hlt_ignored halted=%b addr=%h required=0/0008", o_halted, o_imem_addr);
        end
`endif
        quiesce();
        hlt_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_wrap();
        test_reset_mid();
        test_redirect_out();
        test_hlt();
        quiesce();
        checks++;
        if (exp_q.size() !== 0 || drop_n !== 0) begin
            failures++; $display("FAIL drain pending=%0d drops=%0d required=0/0", exp_q.size(), drop_n);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
